// File: rtl/decimator_n.sv
// decimator_n: decimates a two's-complement sample stream by a run-time
// factor M (1..2^factor_width-1). Pick mode outputs the first sample of each
// group; sum mode outputs the full-precision sum of all M samples.
//
// Handshake: a sample is accepted on a rising clock edge when in_valid=1 and
// hold=0. There is no backpressure. out_valid is a one-cycle strobe that
// qualifies data_out in the cycle after the edge that accepted the group's
// last sample. hold=1 freezes all state and forces out_valid low.
module decimator_n #(
  parameter int word_length  = 8,
  parameter int factor_width = 4,
  parameter int out_length   = word_length + factor_width
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [word_length-1:0]  data_in,
  input  logic                    in_valid,
  input  logic                    hold,
  input  logic [factor_width-1:0] factor,
  input  logic                    mode,
  output logic [out_length-1:0]   data_out,
  output logic                    out_valid,
  output logic [factor_width-1:0] phase
);

  localparam int ext_bits = out_length - word_length;
  localparam logic [factor_width-1:0] one_f = {{(factor_width-1){1'b0}}, 1'b1};

  logic [factor_width-1:0] phase_q, phase_d;
  logic [out_length-1:0]   acc_q, acc_d;
  logic [word_length-1:0]  pick_q, pick_d;
  logic [factor_width-1:0] m_act_q, m_act_d;
  logic                    mode_act_q, mode_act_d;
  logic [out_length-1:0]   data_out_q, data_out_d;
  logic                    out_valid_q, out_valid_d;

  logic                    accept;
  logic                    at_start;
  logic [factor_width-1:0] m_req;
  logic [factor_width-1:0] m_cur;
  logic                    mode_cur;
  logic                    group_end;
  logic [out_length-1:0]   data_ext;
  logic [out_length-1:0]   pick_ext;

  // Decode acceptance and the configuration governing the current sample.
  // At phase 0 the incoming factor/mode take effect immediately so that a
  // one-sample group (M=1) uses the freshly requested configuration.
  always_comb begin
    accept    = in_valid && !hold;
    at_start  = (phase_q == '0);
    m_req     = (factor == '0) ? one_f : factor;
    m_cur     = at_start ? m_req : m_act_q;
    mode_cur  = at_start ? mode : mode_act_q;
    group_end = accept && (phase_q == (m_cur - one_f));
    data_ext  = {{ext_bits{data_in[word_length-1]}}, data_in};
    pick_ext  = {{ext_bits{pick_q[word_length-1]}}, pick_q};
  end

  // Next-state logic for phase, accumulator, captured config and output.
  always_comb begin
    phase_d     = phase_q;
    acc_d       = acc_q;
    pick_d      = pick_q;
    m_act_d     = m_act_q;
    mode_act_d  = mode_act_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    if (accept) begin
      if (at_start) begin
        m_act_d    = m_req;
        mode_act_d = mode;
        acc_d      = data_ext;
        pick_d     = data_in;
      end else begin
        acc_d = acc_q + data_ext;
      end
      if (group_end) begin
        out_valid_d = 1'b1;
        phase_d     = '0;
        if (at_start) begin
          // Single-sample group: the output is the incoming sample itself.
          data_out_d = data_ext;
        end else begin
          data_out_d = mode_cur ? (acc_q + data_ext) : pick_ext;
        end
      end else begin
        phase_d = phase_q + one_f;
      end
    end
  end

  // State registers; reset discards any partial group.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q     <= '0;
      acc_q       <= '0;
      pick_q      <= '0;
      m_act_q     <= one_f;
      mode_act_q  <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      pick_q      <= pick_d;
      m_act_q     <= m_act_d;
      mode_act_q  <= mode_act_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_decimator_n.sv
// Directed testbench for decimator_n with hand-computed expected values.
module tb_decimator_n;

  logic        clock;
  logic        reset;
  logic [7:0]  data_in;
  logic        in_valid;
  logic        hold;
  logic [3:0]  factor;
  logic        mode;
  logic [11:0] data_out;
  logic        out_valid;
  logic [3:0]  phase;

  int checks;
  int failures;

  decimator_n #(.word_length(8), .factor_width(4), .out_length(12)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .in_valid (in_valid),
    .hold     (hold),
    .factor   (factor),
    .mode     (mode),
    .data_out (data_out),
    .out_valid(out_valid),
    .phase    (phase)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one input cycle, then sample 1 unit after the capturing edge.
  task automatic step(input logic [7:0] d, input logic v, input logic h);
    data_in  = d;
    in_valid = v;
    hold     = h;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    data_in  = '0;
    in_valid = 1'b0;
    hold     = 1'b0;
    factor   = 4'd4;
    mode     = 1'b0;
    #2;
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_phase", 32'(phase), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Pick mode, M=4, inputs 1..8.
    factor = 4'd4;
    mode   = 1'b0;
    step(8'd1, 1'b1, 1'b0);
    chk("pick_phase_after_1", 32'(phase), 32'd1);
    chk("pick_no_strobe_1", 32'(out_valid), 32'd0);
    step(8'd2, 1'b1, 1'b0);
    step(8'd3, 1'b1, 1'b0);
    chk("pick_phase_after_3", 32'(phase), 32'd3);
    step(8'd4, 1'b1, 1'b0);
    chk("pick_strobe_4", 32'(out_valid), 32'd1);
    chk("pick_data_4", 32'(data_out), 32'h001);
    chk("pick_phase_wrap", 32'(phase), 32'd0);
    step(8'd5, 1'b1, 1'b0);
    chk("pick_strobe_drop", 32'(out_valid), 32'd0);
    chk("pick_data_hold", 32'(data_out), 32'h001);
    step(8'd6, 1'b1, 1'b0);
    step(8'd7, 1'b1, 1'b0);
    step(8'd8, 1'b1, 1'b0);
    chk("pick_strobe_8", 32'(out_valid), 32'd1);
    chk("pick_data_8", 32'(data_out), 32'h005);

    // Sum mode, M=3: 10+20+30 = 60, then -5*3 = -15.
    factor = 4'd3;
    mode   = 1'b1;
    step(8'd10, 1'b1, 1'b0);
    step(8'd20, 1'b1, 1'b0);
    chk("sum_no_strobe_mid", 32'(out_valid), 32'd0);
    step(8'd30, 1'b1, 1'b0);
    chk("sum_strobe_60", 32'(out_valid), 32'd1);
    chk("sum_data_60", 32'(data_out), 32'h03C);
    step(8'hFB, 1'b1, 1'b0);
    step(8'hFB, 1'b1, 1'b0);
    step(8'hFB, 1'b1, 1'b0);
    chk("sum_data_m15", 32'(data_out), 32'hFF1);

    // Full-scale growth, M=15.
    factor = 4'd15;
    for (int i = 0; i < 15; i++) begin
      step(8'h80, 1'b1, 1'b0);
      if (i == 13) chk("full_phase_14", 32'(phase), 32'd14);
    end
    chk("full_strobe_neg", 32'(out_valid), 32'd1);
    chk("full_data_neg", 32'(data_out), 32'h880);
    for (int i = 0; i < 15; i++) step(8'h7F, 1'b1, 1'b0);
    chk("full_data_pos", 32'(data_out), 32'h771);

    // Hold and gaps, M=2 sum: 7 ... 9 -> 16.
    factor = 4'd2;
    mode   = 1'b1;
    step(8'd7, 1'b1, 1'b0);
    chk("hold_phase_start", 32'(phase), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(8'd50, 1'b1, 1'b1);
      chk("hold_phase_frozen", 32'(phase), 32'd1);
      chk("hold_no_strobe", 32'(out_valid), 32'd0);
    end
    chk("hold_data_frozen", 32'(data_out), 32'h771);
    for (int i = 0; i < 2; i++) begin
      step(8'd60, 1'b0, 1'b0);
      chk("gap_no_strobe", 32'(out_valid), 32'd0);
    end
    step(8'd9, 1'b1, 1'b0);
    chk("gap_strobe", 32'(out_valid), 32'd1);
    chk("gap_data_16", 32'(data_out), 32'h010);
    step(8'd0, 1'b0, 1'b0);
    chk("gap_strobe_single", 32'(out_valid), 32'd0);

    // Mid-group config change: old pick/M=4 group finishes first.
    factor = 4'd4;
    mode   = 1'b0;
    step(8'd1, 1'b1, 1'b0);
    step(8'd2, 1'b1, 1'b0);
    factor = 4'd2;
    mode   = 1'b1;
    step(8'd3, 1'b1, 1'b0);
    chk("cfg_no_early_strobe", 32'(out_valid), 32'd0);
    step(8'd4, 1'b1, 1'b0);
    chk("cfg_old_strobe", 32'(out_valid), 32'd1);
    chk("cfg_old_pick", 32'(data_out), 32'h001);
    step(8'd5, 1'b1, 1'b0);
    chk("cfg_new_phase", 32'(phase), 32'd1);
    step(8'd6, 1'b1, 1'b0);
    chk("cfg_new_strobe", 32'(out_valid), 32'd1);
    chk("cfg_new_sum", 32'(data_out), 32'h00B);

    // Factor 0 behaves as M=1, in both modes.
    factor = 4'd0;
    mode   = 1'b1;
    step(8'hFD, 1'b1, 1'b0);
    chk("m1_sum_strobe", 32'(out_valid), 32'd1);
    chk("m1_sum_data", 32'(data_out), 32'hFFD);
    chk("m1_phase", 32'(phase), 32'd0);
    mode = 1'b0;
    step(8'd6, 1'b1, 1'b0);
    chk("m1_pick_strobe", 32'(out_valid), 32'd1);
    chk("m1_pick_data", 32'(data_out), 32'h006);

    // Async reset mid-group, then a clean M=4 sum group.
    factor = 4'd4;
    mode   = 1'b1;
    step(8'd2, 1'b1, 1'b0);
    step(8'd2, 1'b1, 1'b0);
    chk("rst_pre_phase", 32'(phase), 32'd2);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_data", 32'(data_out), 32'h0);
    chk("rst_async_phase", 32'(phase), 32'd0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(8'd1, 1'b1, 1'b0);
      if (i == 2) chk("rst_no_early_strobe", 32'(out_valid), 32'd0);
    end
    chk("rst_strobe", 32'(out_valid), 32'd1);
    chk("rst_sum_4", 32'(data_out), 32'h004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
